mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 256x16 main-memory read/write port among N_REQ requesters: LSU, instruction fetch, front-panel loader.
- Round-robin arbitration with an optional lock, so the front panel can hold the port across a multi-word examine/deposit sequence.
- Synchronous memory with 1-cycle read latency.
- Read data is returned to the requester that issued the read, one cycle after acceptance.

Parameters:
- N_REQ, 3, number of requesters; index 0 = LSU, 1 = fetch, 2 = front panel.
- AW, 8, address width.
- DW, 16, data width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_val_i  in  N_REQ  per-requester request valid
- req_wen_i  in  N_REQ  per-requester write enable
- req_lock_i  in  N_REQ  per-requester hold-grant request
- req_addr_i  in  N_REQ*AW  packed addresses; requester k at bits [k*AW +: AW]
- req_wdata_i  in  N_REQ*DW  packed write data
- req_rdy_o  out  N_REQ  one-hot accept; the request is taken this cycle
- resp_val_o  out  N_REQ  one-hot read-data valid
- resp_data_o  out  DW  read data, shared by all requesters and qualified by resp_val_o
- mem_val_o  out  1  memory access strobe
- mem_wen_o  out  1  memory write
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  memory write data
- mem_rdata_i  in  DW  memory read data; valid the cycle after a read strobe

Behaviour:
- Reset (asynchronous, rst_ni low):
  - last_grant = N_REQ-1, so requester 0 has first priority.
  - lock_valid = 0, lock_owner = 0.
  - resp_pending = 0, resp_id = 0.
  - All outputs 0.
- Memory is always ready, so at most one request is accepted per cycle with no bubbles.
- Grant selection is combinational within the cycle:
  - If lock_valid and req_val_i[lock_owner]: grant lock_owner.
  - Otherwise grant the first k with req_val_i[k] set, scanning k = last_grant+1 … wrapping mod N_REQ.
  - With no valid request: no grant, mem_val_o = 0, mem address/data = 0, and all state holds.
- On a grant g:
  - req_rdy_o = onehot(g) and mem_val_o = 1.
  - mem_wen_o, mem_addr_o and mem_wdata_o carry requester g's fields.
  - mem_wdata_o = 0 when g is reading.
  - last_grant <= g.
  - Lock register: lock_valid <= req_lock_i[g], lock_owner <= g.
- Lock release: lock_valid clears when the owner is granted with req_lock_i low.
- Lock while the owner is idle: if lock_valid and req_val_i[owner] = 0, other requesters arbitrate normally. The lock stays set, and the owner regains priority the next time it requests.
- Read response:
  - If the granted access is a read: resp_pending <= 1, resp_id <= g; otherwise resp_pending <= 0.
  - In the next cycle: resp_val_o = onehot(resp_id) when resp_pending, else 0.
  - resp_data_o = mem_rdata_i when resp_pending, else 0.
  - Writes produce no response.
- Back-to-back reads from different requesters pipeline: the response for cycle n's read appears in cycle n+1 at the same time as cycle n+1's grant.
- A write in cycle n followed by a read of the same address in cycle n+1 returns the new data; write-first ordering is provided by the memory.
- A requester must hold its request fields stable until it sees req_rdy_o.
- Reset mid-operation: any pending response is discarded; resp_val_o is 0 from the reset assertion onward.
- No combinational path from mem_rdata_i to req_rdy_o or mem_*_o.

Decomposition:
- Shared package core_pkg: localparams ADDR_W = 8, DATA_W = 16, and requester index constants REQ_LSU = 0, REQ_FETCH = 1, REQ_PANEL = 2.
- One natural sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: request vector, last-grant index.
  - Outputs: one-hot grant, grant index, any-grant flag.
- Lock, response pipeline and muxing stay in mem_arbiter.

Test Plan:
- After reset, all three requesters issue reads in the same cycle, to 0x10/0x20/0x30 holding 0x1111/0x2222/0x3333 -> grants 0, 1, 2 on consecutive cycles. resp_val_o = 001/010/100 one cycle later each, with data 0x1111/0x2222/0x3333.
- Requester 1 writes 0xBEEF to 0x05 in cycle n, requester 0 reads 0x05 in cycle n+1 -> resp_val_o[0] in n+2 with resp_data_o = 0xBEEF. No resp_val_o in n+1.
- Requester 2 asserts lock and issues 4 reads (0x00..0x03) while 0 and 1 request continuously -> 4 consecutive grants to 2. After lock drops on the 4th, the next grants go 0 then 1.
- Requester 2 locks, then idles one cycle while 0 requests -> 0 is granted that cycle. When 2 requests again alongside 0, 2 wins.
- No requests for 5 cycles -> mem_val_o = 0, resp_val_o = 0, and last_grant unchanged (checked by the next grant order).
- Assert rst_ni low in the cycle after a read is accepted -> resp_val_o = 0 immediately. After release, the first simultaneous request is granted to requester 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared constants for the main-memory subsystem: memory geometry and the
// fixed requester slot assignment used by the arbiter.
package core_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned NUM_REQ   = 3;

  localparam int unsigned REQ_LSU   = 0;
  localparam int unsigned REQ_FETCH = 1;
  localparam int unsigned REQ_PANEL = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of the main-memory arbiter.
// slave is the arbiter's view; master is the view of whatever surrounds it.
interface mem_arbiter_if
  import core_pkg::*;
#(
  parameter int unsigned N_REQ = NUM_REQ,
  parameter int unsigned AW    = ADDR_W,
  parameter int unsigned DW    = DATA_W
);

  logic [N_REQ-1:0]    req_val_i;
  logic [N_REQ-1:0]    req_wen_i;
  logic [N_REQ-1:0]    req_lock_i;
  logic [N_REQ*AW-1:0] req_addr_i;
  logic [N_REQ*DW-1:0] req_wdata_i;
  logic [N_REQ-1:0]    req_rdy_o;
  logic [N_REQ-1:0]    resp_val_o;
  logic [DW-1:0]       resp_data_o;
  logic                mem_val_o;
  logic                mem_wen_o;
  logic [AW-1:0]       mem_addr_o;
  logic [DW-1:0]       mem_wdata_o;
  logic [DW-1:0]       mem_rdata_i;

  modport slave (
    input  req_val_i, req_wen_i, req_lock_i, req_addr_i, req_wdata_i, mem_rdata_i,
    output req_rdy_o, resp_val_o, resp_data_o,
           mem_val_o, mem_wen_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_val_i, req_wen_i, req_lock_i, req_addr_i, req_wdata_i, mem_rdata_i,
    input  req_rdy_o, resp_val_o, resp_data_o,
           mem_val_o, mem_wen_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_i, wrapping.
module rr_pick
  import core_pkg::*;
#(
  parameter int unsigned N  = NUM_REQ,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = IW'((32'(last_i) + i) % N);
      if (!any_o && req_i[idx]) begin
        any_o     = 1'b1;
        gnt_idx_o = idx;
      end
    end
    if (any_o) gnt_oh_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory port arbiter: round-robin among requesters with a hold-grant
// lock, and a one-deep pipeline that steers read data back to its issuer.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int unsigned N_REQ = NUM_REQ,
  parameter int unsigned AW    = ADDR_W,
  parameter int unsigned DW    = DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mem_arbiter_if.slave      bus
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0]    last_grant_q, last_grant_d;
  logic             lock_valid_q, lock_valid_d;
  logic [IW-1:0]    lock_owner_q, lock_owner_d;
  logic             resp_pending_q, resp_pending_d;
  logic [IW-1:0]    resp_id_q, resp_id_d;

  logic [N_REQ-1:0] rr_oh;
  logic [IW-1:0]    rr_idx;
  logic             rr_any;
  logic             lock_hit;
  logic             gnt_any;
  logic [IW-1:0]    gnt_idx;

  rr_pick #(.N(N_REQ), .IW(IW)) u_rr_pick (
    .req_i     (bus.req_val_i),
    .last_i    (last_grant_q),
    .gnt_oh_o  (rr_oh),
    .gnt_idx_o (rr_idx),
    .any_o     (rr_any)
  );

  always_comb begin
    lock_hit = lock_valid_q && bus.req_val_i[lock_owner_q];
    gnt_any  = rst_ni && (lock_hit || rr_any);
    gnt_idx  = lock_hit ? lock_owner_q : rr_idx;

    bus.req_rdy_o   = '0;
    bus.mem_val_o   = 1'b0;
    bus.mem_wen_o   = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;

    last_grant_d   = last_grant_q;
    lock_valid_d   = lock_valid_q;
    lock_owner_d   = lock_owner_q;
    resp_pending_d = 1'b0;
    resp_id_d      = resp_id_q;

    if (gnt_any) begin
      if (lock_hit) bus.req_rdy_o[lock_owner_q] = 1'b1;
      else          bus.req_rdy_o               = rr_oh;
      bus.mem_val_o  = 1'b1;
      bus.mem_wen_o  = bus.req_wen_i[gnt_idx];
      bus.mem_addr_o = bus.req_addr_i[gnt_idx*AW +: AW];
      if (bus.req_wen_i[gnt_idx]) bus.mem_wdata_o = bus.req_wdata_i[gnt_idx*DW +: DW];

      last_grant_d = gnt_idx;
      // A held lock survives grants to other requesters while its owner idles.
      if (!lock_valid_q || gnt_idx == lock_owner_q) begin
        lock_valid_d = bus.req_lock_i[gnt_idx];
        lock_owner_d = gnt_idx;
      end
      if (!bus.req_wen_i[gnt_idx]) begin
        resp_pending_d = 1'b1;
        resp_id_d      = gnt_idx;
      end
    end

    bus.resp_val_o  = '0;
    bus.resp_data_o = '0;
    if (resp_pending_q) begin
      bus.resp_val_o[resp_id_q] = 1'b1;
      bus.resp_data_o           = bus.mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q   <= IW'(N_REQ - 1);
      lock_valid_q   <= 1'b0;
      lock_owner_q   <= '0;
      resp_pending_q <= 1'b0;
      resp_id_q      <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      lock_valid_q   <= lock_valid_d;
      lock_owner_q   <= lock_owner_d;
      resp_pending_q <= resp_pending_d;
      resp_id_q      <= resp_id_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level arbiter model and a read-response scoreboard.
module tb_mem_arbiter;
  import core_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.N_REQ(N), .AW(8), .DW(16)) bus ();

  mem_arbiter #(.N_REQ(N), .AW(8), .DW(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    bit          act;
    bit          wen;
    bit          lock;
    logic [7:0]  addr;
    logic [15:0] data;
  } txn_t;

  typedef struct {
    int          id;
    logic [15:0] data;
    int          stamp;
  } exp_t;

  txn_t        aq[N][$];
  exp_t        sb[$];
  int          glog[$];
  logic [15:0] shadow[256];
  logic [15:0] mem_arr[256];
  int          m_last, m_lock_own;
  bit          m_lock_v;
  int          cyc, checks, errors;

  function automatic logic [15:0] init_val(int i);
    if (i == 'h10) return 16'h1111;
    if (i == 'h20) return 16'h2222;
    if (i == 'h30) return 16'h3333;
    return 16'(i * 37 + 5);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory with one-cycle read latency; command captured just before the edge.
  initial begin
    bit v, w;
    logic [7:0] a;
    logic [15:0] d;
    for (int i = 0; i < 256; i++) mem_arr[i] = init_val(i);
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      #4;
      v = bus.mem_val_o; w = bus.mem_wen_o; a = bus.mem_addr_o; d = bus.mem_wdata_o;
      @(posedge clk);
      if (v) begin
        if (w) mem_arr[a] = d;
        else   bus.mem_rdata_i <= mem_arr[a];
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a response is due or shown.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_ni) begin
        chk("resp_val_in_reset", 32'(bus.resp_val_o), 0);
      end else if (bus.resp_val_o != '0) begin
        if (sb.size() == 0 || sb[0].stamp > cyc - 1) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got resp_val %b, expected none (cycle %0d)",
                   bus.resp_val_o, cyc);
        end else begin
          e = sb.pop_front();
          chk("resp_val", 32'(bus.resp_val_o), 32'(1) << e.id);
          chk("resp_data", 32'(bus.resp_data_o), 32'(e.data));
        end
      end else begin
        chk("resp_data_idle", 32'(bus.resp_data_o), 0);
        if (sb.size() > 0 && sb[0].stamp <= cyc - 1) begin
          e = sb.pop_front();
          chk("resp_val_missing", 32'(bus.resp_val_o), 32'(1) << e.id);
        end
      end
    end
  end

  function automatic void push(int r, bit act, bit wen, bit lock, logic [7:0] a, logic [15:0] d);
    txn_t t;
    t.act = act; t.wen = wen; t.lock = lock; t.addr = a; t.data = d;
    aq[r].push_back(t);
  endfunction

  function automatic void rd(int r, logic [7:0] a, bit lock = 1'b0);
    push(r, 1'b1, 1'b0, lock, a, 16'(0));
  endfunction

  function automatic void wr(int r, logic [7:0] a, logic [15:0] d);
    push(r, 1'b1, 1'b1, 1'b0, a, d);
  endfunction

  function automatic void idle(int r);
    push(r, 1'b0, 1'b0, 1'b0, 8'(0), 16'(0));
  endfunction

  function automatic int pack_log();
    int p;
    p = glog.size() << 24;
    foreach (glog[i]) p = p | (glog[i] << (4 * (glog.size() - 1 - i)));
    return p;
  endfunction

  function automatic bit any_pending();
    for (int r = 0; r < N; r++) if (aq[r].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    logic [N-1:0]    v, w, l;
    logic [N*8-1:0]  a;
    logic [N*16-1:0] d;
    int g;
    @(negedge clk);
    cyc++;
    v = '0; w = '0; l = '0;
    a = {$urandom(), $urandom()};
    d = {$urandom(), $urandom()};
    for (int r = 0; r < N; r++) begin
      if (aq[r].size() > 0 && aq[r][0].act) begin
        v[r] = 1'b1;
        w[r] = aq[r][0].wen;
        l[r] = aq[r][0].lock;
        a[r*8 +: 8]   = aq[r][0].addr;
        d[r*16 +: 16] = aq[r][0].data;
      end
    end
    bus.req_val_i = v; bus.req_wen_i = w; bus.req_lock_i = l;
    bus.req_addr_i = a; bus.req_wdata_i = d;
    #2;
    g = -1;
    if (m_lock_v && v[m_lock_own]) g = m_lock_own;
    else
      for (int i = 1; i <= N; i++)
        if (g < 0 && v[(m_last + i) % N]) g = (m_last + i) % N;
    if (g < 0) begin
      chk("req_rdy_idle", 32'(bus.req_rdy_o), 0);
      chk("mem_val_idle", 32'(bus.mem_val_o), 0);
      chk("mem_addr_idle", 32'(bus.mem_addr_o), 0);
      chk("mem_wdata_idle", 32'(bus.mem_wdata_o), 0);
    end else begin
      chk("req_rdy", 32'(bus.req_rdy_o), 32'(1) << g);
      chk("mem_val", 32'(bus.mem_val_o), 1);
      chk("mem_wen", 32'(bus.mem_wen_o), 32'(w[g]));
      chk("mem_addr", 32'(bus.mem_addr_o), 32'(a[g*8 +: 8]));
      chk("mem_wdata", 32'(bus.mem_wdata_o), w[g] ? 32'(d[g*16 +: 16]) : 0);
      glog.push_back(g);
      if (!m_lock_v || g == m_lock_own) begin
        m_lock_v   = l[g];
        m_lock_own = g;
      end
      m_last = g;
      if (w[g]) shadow[a[g*8 +: 8]] = d[g*16 +: 16];
      else      sb.push_back('{g, shadow[a[g*8 +: 8]], cyc});
    end
    for (int r = 0; r < N; r++)
      if (aq[r].size() > 0 && (!aq[r][0].act || r == g)) void'(aq[r].pop_front());
  endtask

  task automatic run(int budget);
    int n = 0;
    while (any_pending()) begin
      if (n >= budget) begin
        checks++;
        errors++;
        $display("FAIL run_budget: requests still pending after %0d cycles, expected drained", n);
        for (int r = 0; r < N; r++) aq[r].delete();
        break;
      end
      step();
      n++;
    end
  endtask

  task automatic do_reset(int ncyc);
    @(negedge clk);
    rst_ni = 1'b0;
    bus.req_val_i = '0;
    sb.delete();
    #1;
    chk("rst_resp_val", 32'(bus.resp_val_o), 0);
    chk("rst_req_rdy", 32'(bus.req_rdy_o), 0);
    chk("rst_mem_val", 32'(bus.mem_val_o), 0);
    repeat (ncyc) @(negedge clk);
    rst_ni = 1'b1;
    m_last = N - 1; m_lock_v = 1'b0; m_lock_own = 0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    m_last = N - 1; m_lock_v = 1'b0; m_lock_own = 0;

    // Outputs stay quiet under reset even with every requester asking.
    bus.req_val_i = '1; bus.req_wen_i = '0; bus.req_lock_i = '0;
    bus.req_addr_i = '0; bus.req_wdata_i = '0;
    #12;
    chk("reset_req_rdy", 32'(bus.req_rdy_o), 0);
    chk("reset_mem_val", 32'(bus.mem_val_o), 0);
    chk("reset_resp_val", 32'(bus.resp_val_o), 0);
    chk("reset_resp_data", 32'(bus.resp_data_o), 0);
    chk("reset_mem_addr", 32'(bus.mem_addr_o), 0);
    bus.req_val_i = '0;
    @(negedge clk);
    rst_ni = 1'b1;

    glog.delete();
    rd(REQ_LSU, 8'h10); rd(REQ_FETCH, 8'h20); rd(REQ_PANEL, 8'h30);
    run(20);
    chk("order_after_reset", 32'(pack_log()), 32'h0300_0012);

    glog.delete();
    wr(REQ_FETCH, 8'h05, 16'hBEEF); idle(REQ_LSU); rd(REQ_LSU, 8'h05);
    run(20);
    chk("order_write_read", 32'(pack_log()), 32'h0200_0010);
    chk("shadow_beef", 32'(shadow[5]), 32'hBEEF);

    glog.delete();
    idle(REQ_LSU); idle(REQ_FETCH);
    rd(REQ_PANEL, 8'h00, 1'b1); rd(REQ_PANEL, 8'h01, 1'b1);
    rd(REQ_PANEL, 8'h02, 1'b1); rd(REQ_PANEL, 8'h03, 1'b0);
    rd(REQ_LSU, 8'h08); rd(REQ_FETCH, 8'h09);
    run(30);
    chk("order_lock_burst", 32'(pack_log()), 32'h0622_2201);

    glog.delete();
    rd(REQ_PANEL, 8'h11, 1'b1); idle(REQ_PANEL); rd(REQ_PANEL, 8'h12, 1'b0);
    idle(REQ_LSU); rd(REQ_LSU, 8'h13); rd(REQ_LSU, 8'h14);
    run(30);
    chk("order_lock_idle", 32'(pack_log()), 32'h0400_2020);

    glog.delete();
    repeat (5) step();
    rd(REQ_LSU, 8'h21); rd(REQ_FETCH, 8'h22); rd(REQ_PANEL, 8'h23);
    run(20);
    chk("order_after_idle", 32'(pack_log()), 32'h0300_0120);

    rd(REQ_LSU, 8'h40);
    step();
    do_reset(2);
    glog.delete();
    rd(REQ_LSU, 8'h41); rd(REQ_FETCH, 8'h42); rd(REQ_PANEL, 8'h43);
    run(20);
    chk("order_after_midreset", 32'(pack_log()), 32'h0300_0012);

    repeat (300) begin
      for (int r = 0; r < N; r++)
        if (aq[r].size() < 2)
          push(r, $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0,
               $urandom_range(3, 0) == 0, 8'($urandom_range(15, 0)), 16'($urandom()));
      step();
    end
    run(500);
    repeat (3) step();
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
